motor_pwm_driver: RTL

// - Downstream stage of direction_control: consumes one 5-bit motor-controller command (MC1 or MC2)
//   and drives one H-bridge channel. Instantiated twice: right side (MC1) and left side (MC2).
// - Produces a fixed-frequency PWM enable plus two bridge direction lines.
// - Inserts a dead time on every forward<->reverse change and applies duty changes glitch-free.

---
 rtl/motor_pwm_driver_if.sv | 18 +
 rtl/motor_pwm_driver.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver_if.sv
// motor_pwm_driver_if
// Groups one H-bridge channel's command input and its drive outputs.
//   MC_CMD   [1:0] direction (00 fwd, 01/11 neutral, 10 rev), [4:2] power code
//   PWM_OUT  bridge enable, high during the on-portion of the PWM period
//   IN_A     bridge forward line
//   IN_B     bridge reverse line
//   ACTIVE   high while the channel is driving forward or reverse
// Modports: master (command source / observer), slave (the driver).
interface motor_pwm_driver_if;
  logic [4:0] MC_CMD;
  logic       PWM_OUT;
  logic       IN_A;
  logic       IN_B;
  logic       ACTIVE;

  modport master (output MC_CMD, input PWM_OUT, IN_A, IN_B, ACTIVE);
  modport slave  (input MC_CMD, output PWM_OUT, IN_A, IN_B, ACTIVE);
endinterface

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
// Drives one H-bridge channel from a 5-bit motor-controller command: a fixed
// frequency PWM enable plus forward/reverse bridge lines. Every forward<->reverse
// change passes through a dead time with both lines low, and duty changes are
// only applied at the period boundary so no PWM pulse is ever cut or stretched.
// Ports:
//   CLK  system clock, all logic on posedge
//   RST  synchronous active-high reset
//   bus  motor_pwm_driver_if.slave (MC_CMD in; PWM_OUT, IN_A, IN_B, ACTIVE out)
// Build option:
//   SOFT_START_EN  when defined, entering FWD/REV starts from zero duty and the
//                  duty ramps up one eighth of the period every RAMP_PERIODS
//                  periods; reductions still apply at the next boundary.
module motor_pwm_driver #(
  parameter int PERIOD_CYCLES = 80,
  parameter int CNT_W         = 12,
  parameter int DEAD_CYCLES   = 16,
  parameter int RAMP_PERIODS  = 2
) (
  input logic              CLK,
  input logic              RST,
  motor_pwm_driver_if.slave bus
);

  if ((PERIOD_CYCLES % 8) != 0 || PERIOD_CYCLES > (2 ** CNT_W) ||
      DEAD_CYCLES < 1 || RAMP_PERIODS < 1) begin : g_bad_params
    $error("motor_pwm_driver: invalid parameter set");
  end

  typedef enum logic [1:0] {ST_NEUTRAL, ST_FWD, ST_REV, ST_DEAD} state_t;

  localparam int                DEAD_W    = $clog2(DEAD_CYCLES + 1);
  localparam logic [CNT_W:0]    STEP      = (CNT_W + 1)'(PERIOD_CYCLES / 8);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  // On-time for a power code: (code+1) eighths of the period.
  function automatic logic [CNT_W:0] target_duty(input logic [2:0] code);
    logic [CNT_W:0] eighths;
    eighths = (CNT_W + 1)'(code) + (CNT_W + 1)'(1);
    return eighths * STEP;
  endfunction

  state_t             state_q, state_n;
  logic [4:0]         cmd_q;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [CNT_W:0]     duty_q, duty_n;
  logic [DEAD_W-1:0]  dead_q, dead_n;
  logic               pwm_q, pwm_n;
  logic               boundary, dir_fwd, dir_rev, dir_neu, enter_run;
  logic [CNT_W:0]     target;

  assign boundary = (cnt_q == CNT_LAST);
  assign dir_fwd  = (cmd_q[1:0] == 2'b00);
  assign dir_rev  = (cmd_q[1:0] == 2'b10);
  assign dir_neu  = cmd_q[0];
  assign target   = target_duty(cmd_q[4:2]);
  assign cnt_n    = boundary ? '0 : cnt_q + CNT_W'(1);

  // Next-state logic. Going neutral is immediate; every drive change that could
  // shoot through the bridge is boundary-gated and routed through DEAD.
  always_comb begin
    state_n   = state_q;
    dead_n    = '0;
    enter_run = 1'b0;
    case (state_q)
      ST_NEUTRAL: begin
        if (boundary && dir_fwd) begin
          state_n   = ST_FWD;
          enter_run = 1'b1;
        end else if (boundary && dir_rev) begin
          state_n   = ST_REV;
          enter_run = 1'b1;
        end
      end
      ST_FWD: begin
        if (dir_neu)                   state_n = ST_NEUTRAL;
        else if (boundary && dir_rev)  state_n = ST_DEAD;
      end
      ST_REV: begin
        if (dir_neu)                   state_n = ST_NEUTRAL;
        else if (boundary && dir_fwd)  state_n = ST_DEAD;
      end
      ST_DEAD: begin
        // Dead time always runs to completion; the new direction is picked up
        // from NEUTRAL at a later boundary using whatever cmd_q holds then.
        if (dead_q == DEAD_LAST) state_n = ST_NEUTRAL;
        else                     dead_n  = dead_q + DEAD_W'(1);
      end
      default: state_n = ST_NEUTRAL;
    endcase
  end

`ifdef SOFT_START_EN
  localparam int               RAMP_W    = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);

  logic [RAMP_W-1:0] ramp_q, ramp_n;

  always_comb begin
    duty_n = duty_q;
    ramp_n = ramp_q;
    if (boundary) begin
      if (enter_run) begin
        duty_n = '0;
        ramp_n = '0;
      end else begin
        ramp_n = (ramp_q == RAMP_LAST) ? '0 : ramp_q + RAMP_W'(1);
        if (target < duty_q)
          duty_n = target;
        else if (ramp_q == RAMP_LAST && duty_q < target)
          duty_n = duty_q + STEP;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) ramp_q <= '0;
    else     ramp_q <= ramp_n;
  end
`else
  assign duty_n = boundary ? target : duty_q;
`endif

  // PWM is computed from next-cycle state/count/duty so the registered output
  // lines up with the cycle the counter and FSM are actually in.
  assign pwm_n = (state_n == ST_FWD || state_n == ST_REV) && ({1'b0, cnt_n} < duty_n);

  // Register stage: command capture, counter, duty, FSM and PWM output
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_NEUTRAL;
      cmd_q   <= 5'b00001;
      cnt_q   <= '0;
      duty_q  <= '0;
      dead_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cmd_q   <= bus.MC_CMD;
      cnt_q   <= cnt_n;
      duty_q  <= duty_n;
      dead_q  <= dead_n;
      pwm_q   <= pwm_n;
    end
  end

  assign bus.PWM_OUT = pwm_q;
  assign bus.IN_A    = (state_q == ST_FWD);
  assign bus.IN_B    = (state_q == ST_REV);
  assign bus.ACTIVE  = (state_q == ST_FWD) || (state_q == ST_REV);

endmodule
